// File: rtl/rx_ip_tcp_strip_pkg.sv
// Shared types and constants for the receive-path IPv4 header strip stage.
// Optional build macro used by this slice: RX_IP_HDR_CHKSUM_CHECK_EN.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_INTERFACE_BYTES
`define MAC_INTERFACE_BYTES 32
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef IPPROTO_TCP
`define IPPROTO_TCP 8'd6
`endif

package rx_ip_tcp_strip_pkg;

   localparam int IPV4_HDR_BYTES        = 20;
   localparam int IP_STRIP_HOLD_BYTES   = `MAC_INTERFACE_BYTES - IPV4_HDR_BYTES;
   localparam int IPV4_HDR_W            = IPV4_HDR_BYTES * 8;
   localparam int IP_STRIP_HOLD_W       = IP_STRIP_HOLD_BYTES * 8;
   // Smallest IPv4/TCP packet: 20 B IP header + 20 B TCP header.
   localparam int IPV4_MIN_TCP_PKT_BYTES = 40;

   // Fixed 20-byte IPv4 header, first byte on the MSB side.
   typedef struct packed {
      logic [3:0]            version;
      logic [3:0]            ihl;
      logic [7:0]            tos;
      logic [`TOT_LEN_W-1:0] tot_len;
      logic [15:0]           id;
      logic [15:0]           flags_frag;
      logic [7:0]            ttl;
      logic [7:0]            protocol;
      logic [15:0]           chksum;
      logic [`IP_ADDR_W-1:0] src_ip;
      logic [`IP_ADDR_W-1:0] dst_ip;
   } ipv4_hdr;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR_OUT = 3'd1,
      ST_DATA    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DROP    = 3'd4
   } strip_state_e;

   // Field-level acceptance of a header: plain IPv4, no options, TCP, room for a TCP header.
   function automatic logic hdr_fields_ok(input ipv4_hdr h);
      return (h.version == 4'd4) &&
             (h.ihl == 4'd5) &&
             (h.protocol == `IPPROTO_TCP) &&
             (h.tot_len >= `TOT_LEN_W'(IPV4_MIN_TCP_PKT_BYTES));
   endfunction

endpackage

// File: rtl/rx_ip_tcp_strip_chksum.sv
// IPv4 header checksum verifier: ones'-complement sum of the ten header words.
// Only present when RX_IP_HDR_CHKSUM_CHECK_EN is defined, so the default build
// carries no sum logic and no orphan module.
`ifdef RX_IP_HDR_CHKSUM_CHECK_EN
module ip_hdr_chksum_check
   import rx_ip_tcp_strip_pkg::*;
(
   input  logic [IPV4_HDR_W-1:0] hdr,
   output logic                  ok
);

   // End-around-carry sum; two folds are enough for ten 16-bit words.
   function automatic logic [15:0] ones_sum(input logic [IPV4_HDR_W-1:0] h);
      logic [19:0] acc;
      acc = 20'd0;
      for (int i = 0; i < IPV4_HDR_BYTES / 2; i++) begin
         acc = acc + {4'd0, h[i*16 +: 16]};
      end
      acc = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
      acc = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
      return acc[15:0];
   endfunction

   // A correct header (checksum field included) sums to all-ones.
   always_comb begin
      ok = (ones_sum(hdr) == 16'hFFFF);
   end

endmodule
`endif

// File: rtl/rx_ip_tcp_strip.sv
// Receive-path IPv4 header strip: validates the 20-byte IPv4 header on the first
// beat, emits one header beat (src/dst IP, TCP length) and then the TCP segment
// realigned to the bus MSB. Non-TCP and malformed packets are swallowed and counted.
// Optional build macro: RX_IP_HDR_CHKSUM_CHECK_EN (adds header checksum check).
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif

module rx_ip_tcp_strip
   import rx_ip_tcp_strip_pkg::*;
#(
   parameter int DROP_CNT_W = 16
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        src_ip_strip_rx_data_val,
   output logic                        ip_strip_src_rx_data_rdy,
   input  logic [`MAC_INTERFACE_W-1:0] src_ip_strip_rx_data,
   input  logic                        src_ip_strip_rx_last,
   input  logic [`MAC_PADBYTES_W-1:0]  src_ip_strip_rx_padbytes,
   output logic                        ip_strip_dst_rx_hdr_val,
   input  logic                        dst_ip_strip_rx_hdr_rdy,
   output logic [`IP_ADDR_W-1:0]       ip_strip_dst_rx_src_ip,
   output logic [`IP_ADDR_W-1:0]       ip_strip_dst_rx_dst_ip,
   output logic [`TOT_LEN_W-1:0]       ip_strip_dst_rx_tcp_len,
   output logic                        ip_strip_dst_rx_data_val,
   input  logic                        dst_ip_strip_rx_data_rdy,
   output logic [`MAC_INTERFACE_W-1:0] ip_strip_dst_rx_data,
   output logic                        ip_strip_dst_rx_last,
   output logic [`MAC_PADBYTES_W-1:0]  ip_strip_dst_rx_padbytes,
   output logic [DROP_CNT_W-1:0]       drop_cnt
);

   // Byte counts expressed in padbyte width for the tail arithmetic.
   localparam logic [`MAC_PADBYTES_W-1:0] PAD_HOLD = `MAC_PADBYTES_W'(IP_STRIP_HOLD_BYTES);
   localparam logic [`MAC_PADBYTES_W-1:0] PAD_HDR  = `MAC_PADBYTES_W'(IPV4_HDR_BYTES);
   localparam logic [`TOT_LEN_W-1:0]      HDR_LEN  = `TOT_LEN_W'(IPV4_HDR_BYTES);

   strip_state_e                  state_r;
   logic [IP_STRIP_HOLD_W-1:0]    hold_r;
   logic [`IP_ADDR_W-1:0]         src_ip_r;
   logic [`IP_ADDR_W-1:0]         dst_ip_r;
   logic [`TOT_LEN_W-1:0]         tcp_len_r;
   logic [`MAC_PADBYTES_W-1:0]    pad_r;
   logic [DROP_CNT_W-1:0]         drop_cnt_r;

   ipv4_hdr                       hdr_s;
   logic                          chksum_ok_s;
   logic                          hdr_good_s;
   logic                          hdr_unused_s;
   logic                          in_rdy_s;
   logic                          in_fire_s;
   logic                          tail_fits_s;
   logic                          hdr_val_s;
   logic                          out_val_s;
   logic [`MAC_INTERFACE_W-1:0]   out_data_s;
   logic                          out_last_s;
   logic [`MAC_PADBYTES_W-1:0]    out_pad_s;

   // Saturating increment so the counter parks at all-ones.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign hdr_s = ipv4_hdr'(src_ip_strip_rx_data[`MAC_INTERFACE_W-1 -: IPV4_HDR_W]);
   // Header fields this stage forwards or checks nowhere else.
   assign hdr_unused_s = ^{hdr_s.tos, hdr_s.id, hdr_s.flags_frag, hdr_s.ttl, hdr_s.chksum};

`ifdef RX_IP_HDR_CHKSUM_CHECK_EN
   ip_hdr_chksum_check u_chksum (
      .hdr (src_ip_strip_rx_data[`MAC_INTERFACE_W-1 -: IPV4_HDR_W]),
      .ok  (chksum_ok_s)
   );
`else
   assign chksum_ok_s = 1'b1;
`endif

   assign hdr_good_s  = hdr_fields_ok(hdr_s) && chksum_ok_s;
   assign in_fire_s   = src_ip_strip_rx_data_val && in_rdy_s;
   // Last input beat whose valid bytes all fit beside the 12 held bytes.
   assign tail_fits_s = (src_ip_strip_rx_padbytes >= PAD_HOLD);

   // Per-state handshake steering and output beat formation.
   always_comb begin
      in_rdy_s   = 1'b0;
      hdr_val_s  = 1'b0;
      out_val_s  = 1'b0;
      out_data_s = {`MAC_INTERFACE_W{1'b0}};
      out_last_s = 1'b0;
      out_pad_s  = {`MAC_PADBYTES_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            in_rdy_s = 1'b1;
         end
         ST_HDR_OUT: begin
            hdr_val_s = 1'b1;
         end
         ST_DATA: begin
            in_rdy_s  = dst_ip_strip_rx_data_rdy;
            out_val_s = src_ip_strip_rx_data_val;
            if (src_ip_strip_rx_data_val) begin
               out_data_s = {hold_r, src_ip_strip_rx_data[`MAC_INTERFACE_W-1 -: IPV4_HDR_W]};
               if (src_ip_strip_rx_last && tail_fits_s) begin
                  out_last_s = 1'b1;
                  out_pad_s  = src_ip_strip_rx_padbytes - PAD_HOLD;
               end else begin
                  out_last_s = 1'b0;
                  out_pad_s  = {`MAC_PADBYTES_W{1'b0}};
               end
            end else begin
               out_data_s = {`MAC_INTERFACE_W{1'b0}};
               out_last_s = 1'b0;
               out_pad_s  = {`MAC_PADBYTES_W{1'b0}};
            end
         end
         ST_DRAIN: begin
            out_val_s  = 1'b1;
            out_last_s = 1'b1;
            out_data_s = {hold_r, {IPV4_HDR_W{1'b0}}};
            out_pad_s  = pad_r + PAD_HDR;
         end
         ST_DROP: begin
            in_rdy_s = 1'b1;
         end
         default: begin
            in_rdy_s   = 1'b0;
            hdr_val_s  = 1'b0;
            out_val_s  = 1'b0;
            out_data_s = {`MAC_INTERFACE_W{1'b0}};
            out_last_s = 1'b0;
            out_pad_s  = {`MAC_PADBYTES_W{1'b0}};
         end
      endcase
   end

   // Packet FSM: header capture, hold register, tail bookkeeping and drop counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         hold_r     <= {IP_STRIP_HOLD_W{1'b0}};
         src_ip_r   <= {`IP_ADDR_W{1'b0}};
         dst_ip_r   <= {`IP_ADDR_W{1'b0}};
         tcp_len_r  <= {`TOT_LEN_W{1'b0}};
         pad_r      <= {`MAC_PADBYTES_W{1'b0}};
         drop_cnt_r <= {DROP_CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_fire_s) begin
                  src_ip_r  <= hdr_s.src_ip;
                  dst_ip_r  <= hdr_s.dst_ip;
                  tcp_len_r <= hdr_s.tot_len - HDR_LEN;
                  hold_r    <= src_ip_strip_rx_data[IP_STRIP_HOLD_W-1:0];
                  if (src_ip_strip_rx_last) begin
                     // A single-beat packet cannot hold IPv4 + TCP headers.
                     drop_cnt_r <= sat_inc(drop_cnt_r);
                     state_r    <= ST_IDLE;
                  end else if (!hdr_good_s) begin
                     drop_cnt_r <= sat_inc(drop_cnt_r);
                     state_r    <= ST_DROP;
                  end else begin
                     state_r <= ST_HDR_OUT;
                  end
               end
            end
            ST_HDR_OUT: begin
               if (dst_ip_strip_rx_hdr_rdy) begin
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (in_fire_s) begin
                  hold_r <= src_ip_strip_rx_data[IP_STRIP_HOLD_W-1:0];
                  if (src_ip_strip_rx_last && tail_fits_s) begin
                     state_r <= ST_IDLE;
                  end else if (src_ip_strip_rx_last) begin
                     // Held bytes still valid: flush them in a separate beat.
                     pad_r   <= src_ip_strip_rx_padbytes;
                     state_r <= ST_DRAIN;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DRAIN: begin
               if (dst_ip_strip_rx_data_rdy) begin
                  state_r <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (in_fire_s && src_ip_strip_rx_last) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ip_strip_src_rx_data_rdy = in_rdy_s;
   assign ip_strip_dst_rx_hdr_val   = hdr_val_s;
   assign ip_strip_dst_rx_src_ip    = src_ip_r;
   assign ip_strip_dst_rx_dst_ip    = dst_ip_r;
   assign ip_strip_dst_rx_tcp_len   = tcp_len_r;
   assign ip_strip_dst_rx_data_val  = out_val_s;
   assign ip_strip_dst_rx_data      = out_data_s;
   assign ip_strip_dst_rx_last      = out_last_s;
   assign ip_strip_dst_rx_padbytes  = out_pad_s;
   assign drop_cnt                  = drop_cnt_r;

endmodule

// File: tb/tb_rx_ip_tcp_strip.sv
// Directed self-checking bench for rx_ip_tcp_strip.
// Optional build macro exercised: RX_IP_HDR_CHKSUM_CHECK_EN.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif

module tb_rx_ip_tcp_strip;

   localparam logic [31:0] SRC = 32'hC0A8_0001;
   localparam logic [31:0] DST = 32'h0A00_0002;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic                        in_val;
   logic                        in_rdy;
   logic [`MAC_INTERFACE_W-1:0] in_data;
   logic                        in_last;
   logic [`MAC_PADBYTES_W-1:0]  in_pad;
   logic                        hdr_val;
   logic                        hdr_rdy;
   logic [`IP_ADDR_W-1:0]       src_ip;
   logic [`IP_ADDR_W-1:0]       dst_ip;
   logic [`TOT_LEN_W-1:0]       tcp_len;
   logic                        out_val;
   logic                        out_rdy;
   logic [`MAC_INTERFACE_W-1:0] out_data;
   logic                        out_last;
   logic [`MAC_PADBYTES_W-1:0]  out_pad;
   logic [15:0]                 drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rx_ip_tcp_strip dut (
      .clk                      (clk),
      .rst                      (rst),
      .src_ip_strip_rx_data_val (in_val),
      .ip_strip_src_rx_data_rdy (in_rdy),
      .src_ip_strip_rx_data     (in_data),
      .src_ip_strip_rx_last     (in_last),
      .src_ip_strip_rx_padbytes (in_pad),
      .ip_strip_dst_rx_hdr_val  (hdr_val),
      .dst_ip_strip_rx_hdr_rdy  (hdr_rdy),
      .ip_strip_dst_rx_src_ip   (src_ip),
      .ip_strip_dst_rx_dst_ip   (dst_ip),
      .ip_strip_dst_rx_tcp_len  (tcp_len),
      .ip_strip_dst_rx_data_val (out_val),
      .dst_ip_strip_rx_data_rdy (out_rdy),
      .ip_strip_dst_rx_data     (out_data),
      .ip_strip_dst_rx_last     (out_last),
      .ip_strip_dst_rx_padbytes (out_pad),
      .drop_cnt                 (drop_cnt)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // IPv4 header with a correct checksum unless bad_ck is set.
   function automatic logic [159:0] make_hdr(input logic [7:0] proto, input logic [15:0] tot,
                                             input bit bad_ck);
      logic [159:0] h;
      logic [19:0]  acc;
      h = {4'h4, 4'h5, 8'h00, tot, 16'h1C46, 16'h4000, 8'h40, proto, 16'h0000, SRC, DST};
      acc = 20'd0;
      for (int i = 0; i < 10; i++) acc = acc + {4'd0, h[i*16 +: 16]};
      acc = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
      acc = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
      h[79:64] = bad_ck ? (~acc[15:0] ^ 16'h0101) : ~acc[15:0];
      return h;
   endfunction

   task automatic drive(input logic [255:0] d, input logic l, input logic [4:0] p);
      in_val = 1'b1; in_data = d; in_last = l; in_pad = p;
   endtask

   task automatic idle_in();
      in_val = 1'b0; in_data = 256'd0; in_last = 1'b0; in_pad = 5'd0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // First beat of a packet: accepted in IDLE with no output activity.
   task automatic first_beat(input string tag, input logic [255:0] d, input logic l);
      drive(d, l, 5'd0);
      @(negedge clk);
      chk({tag, "_b0_rdy"}, in_rdy, 1'b1);
      chk({tag, "_b0_hdrval"}, hdr_val, 1'b0);
      step();
      idle_in();
   endtask

   // Wait (bounded) for the header beat and check its fields; hdr_rdy must be high.
   task automatic expect_hdr(input string tag, input logic [15:0] len);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (hdr_val === 1'b1) seen = 1'b1;
         else step();
      end
      chk({tag, "_hdr_seen"}, seen, 1'b1);
      if (seen) begin
         chk({tag, "_src"}, src_ip, SRC);
         chk({tag, "_dst"}, dst_ip, DST);
         chk({tag, "_tcplen"}, tcp_len, len);
         chk({tag, "_hdr_inrdy"}, in_rdy, 1'b0);
         chk({tag, "_hdr_outval"}, out_val, 1'b0);
         step();
      end
   endtask

   // One accepted DATA beat with its expected realigned output.
   task automatic data_beat(input string tag, input logic [255:0] d, input logic l,
                            input logic [4:0] p, input logic [255:0] ed, input logic el,
                            input logic [4:0] ep);
      drive(d, l, p);
      @(negedge clk);
      chk({tag, "_val"}, out_val, 1'b1);
      chk({tag, "_data"}, out_data, ed);
      chk({tag, "_last"}, out_last, el);
      chk({tag, "_pad"}, out_pad, ep);
      chk({tag, "_inrdy"}, in_rdy, 1'b1);
      step();
      idle_in();
   endtask

   // Beat of a dropped packet: consumed, nothing emitted.
   task automatic drop_beat(input string tag, input logic [255:0] d, input logic l);
      drive(d, l, 5'd0);
      @(negedge clk);
      chk({tag, "_rdy"}, in_rdy, 1'b1);
      chk({tag, "_outval"}, out_val, 1'b0);
      chk({tag, "_hdrval"}, hdr_val, 1'b0);
      step();
      idle_in();
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_outval"}, out_val, 1'b0);
      chk({tag, "_outdata"}, out_data, 256'd0);
      chk({tag, "_inrdy"}, in_rdy, 1'b1);
      step();
   endtask

   // 40-byte IPv4/TCP packet: two input beats, one output beat.
   task automatic min_packet(input string tag);
      logic [95:0]  a;
      logic [255:0] b1;
      a  = 96'h0050_01BB_0000_0001_0000_0000;
      b1 = {64'h5010_FFFF_ABCD_0000, 192'd0};
      first_beat(tag, {make_hdr(8'd6, 16'd40, 1'b0), a}, 1'b0);
      expect_hdr(tag, 16'd20);
      data_beat({tag, "_d0"}, b1, 1'b1, 5'd24, {a, b1[255:96]}, 1'b1, 5'd12);
      idle_check({tag, "_end"});
   endtask

   initial begin
      logic [95:0]  a;
      logic [255:0] b0, b1, b2, b3;
      logic [15:0]  dc;
      idle_in();
      hdr_rdy = 1'b1;
      out_rdy = 1'b1;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_hdrval", hdr_val, 1'b0);
      chk("rst_outval", out_val, 1'b0);
      chk("rst_inrdy", in_rdy, 1'b1);
      chk("rst_dropcnt", drop_cnt, 16'd0);
      chk("rst_data", out_data, 256'd0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_pad", out_pad, 5'd0);
      chk("rst_src", src_ip, 32'd0);
      chk("rst_tcplen", tcp_len, 16'd0);
      step();

      // Minimum packet
      min_packet("t1");

      // 100-byte packet, tail fits with the held bytes
      a  = 96'hAAAA_0001_AAAA_0002_AAAA_0003;
      b1 = {128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000};
      b2 = {128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
      b3 = {32'hDEAD_BEEF, 224'd0};
      b0 = {make_hdr(8'd6, 16'd100, 1'b0), a};
      first_beat("t2", b0, 1'b0);
      expect_hdr("t2", 16'd80);
      data_beat("t2_d0", b1, 1'b0, 5'd0, {a, b1[255:96]}, 1'b0, 5'd0);
      data_beat("t2_d1", b2, 1'b0, 5'd0, {b1[95:0], b2[255:96]}, 1'b0, 5'd0);
      data_beat("t2_d2", b3, 1'b1, 5'd28, {b2[95:0], b3[255:96]}, 1'b1, 5'd16);
      idle_check("t2_end");

      // 60-byte packet, last beat p = 4: extra drain beat, held one cycle
      b1 = {160'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF_D0D1_D2D3, 64'hE0E1_E2E3_E4E5_E6E7, 32'd0};
      first_beat("t3", {make_hdr(8'd6, 16'd60, 1'b0), a}, 1'b0);
      expect_hdr("t3", 16'd40);
      data_beat("t3_d0", b1, 1'b1, 5'd4, {a, b1[255:96]}, 1'b0, 5'd0);
      out_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t3_drain_val", out_val, 1'b1);
         chk("t3_drain_data", out_data, {b1[95:0], 160'd0});
         chk("t3_drain_last", out_last, 1'b1);
         chk("t3_drain_pad", out_pad, 5'd24);
         chk("t3_drain_inrdy", in_rdy, 1'b0);
         step();
         out_rdy = 1'b1;
      end
      idle_check("t3_end");

      // UDP packet dropped, then a good packet
      first_beat("t4", {make_hdr(8'd17, 16'd84, 1'b0), a}, 1'b0);
      @(negedge clk);
      chk("t4_dropcnt1", drop_cnt, 16'd1);
      chk("t4_hdrval", hdr_val, 1'b0);
      step();
      drop_beat("t4_b1", b1, 1'b0);
      drop_beat("t4_b2", b2, 1'b1);
      idle_check("t4_end");
      @(negedge clk);
      chk("t4_dropcnt_final", drop_cnt, 16'd1);
      step();
      min_packet("t4_good");

      // Backpressure: header stalled 5 cycles, data ready 1-0-1
      hdr_rdy = 1'b0;
      b0 = {make_hdr(8'd6, 16'd100, 1'b0), a};
      first_beat("t5", b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_stall_hdrval", hdr_val, 1'b1);
         chk("t5_stall_tcplen", tcp_len, 16'd80);
         chk("t5_stall_inrdy", in_rdy, 1'b0);
         step();
      end
      hdr_rdy = 1'b1;
      expect_hdr("t5", 16'd80);
      data_beat("t5_d0", b1, 1'b0, 5'd0, {a, b1[255:96]}, 1'b0, 5'd0);
      out_rdy = 1'b0;
      drive(b2, 1'b0, 5'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t5_bp_val", out_val, 1'b1);
         chk("t5_bp_inrdy", in_rdy, 1'b0);
         chk("t5_bp_data", out_data, {b1[95:0], b2[255:96]});
         step();
      end
      out_rdy = 1'b1;
      data_beat("t5_d1", b2, 1'b0, 5'd0, {b1[95:0], b2[255:96]}, 1'b0, 5'd0);
      data_beat("t5_d2", b3, 1'b1, 5'd28, {b2[95:0], b3[255:96]}, 1'b1, 5'd16);
      idle_check("t5_end");

      // Reset in the middle of DATA
      first_beat("t6", b0, 1'b0);
      expect_hdr("t6", 16'd80);
      data_beat("t6_d0", b1, 1'b0, 5'd0, {a, b1[255:96]}, 1'b0, 5'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_hdrval", hdr_val, 1'b0);
      chk("t6_rst_outval", out_val, 1'b0);
      chk("t6_rst_inrdy", in_rdy, 1'b1);
      chk("t6_rst_dropcnt", drop_cnt, 16'd0);
      chk("t6_rst_tcplen", tcp_len, 16'd0);
      step();
      min_packet("t6_after");

`ifdef RX_IP_HDR_CHKSUM_CHECK_EN
      // Corrupted header checksum is dropped
      first_beat("t7", {make_hdr(8'd6, 16'd40, 1'b1), a}, 1'b0);
      @(negedge clk);
      chk("t7_dropcnt", drop_cnt, 16'd1);
      chk("t7_hdrval", hdr_val, 1'b0);
      step();
      drop_beat("t7_b1", b1, 1'b1);
      idle_check("t7_end");
`endif

      // Saturation: single-beat packets are always dropped, one per cycle
      dc = drop_cnt;
      drive({make_hdr(8'd6, 16'd40, 1'b0), a}, 1'b1, 5'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t8_dropcnt3", drop_cnt, dc + 16'd3);
      chk("t8_hdrval", hdr_val, 1'b0);
      repeat (65536) @(posedge clk);
      #1 idle_in();
      @(negedge clk);
      chk("t8_saturated", drop_cnt, 16'hFFFF);
      chk("t8_outval", out_val, 1'b0);
      step();
      step();
      @(negedge clk);
      chk("t8_still_sat", drop_cnt, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
